oam_dma: RTL
============

Name: oam_dma

Overview:
- Sprite DMA engine that sits on the CPU system bus beside the 6502 core.
- Watches CPU writes for the $4014 trigger register and stalls the CPU through its RDY input.
- While the CPU is stalled, copies 256 bytes from CPU page $XX00-$XXFF to the PPU OAM data port $2004 as alternating read/write bus cycles.
- When the copy finishes, releases the bus and the CPU resumes.

Parameters:
- ADDR_N, 16, system address width.
- DATA_N, 8, system data width.
- TRIG_ADDR, 16'h4014, address whose CPU write starts a transfer.
- OAM_ADDR, 16'h2004, destination port address.
- LEN, 256, bytes per transfer; must be a power of two no larger than 2^DATA_N.

Ports:
- clk  in  1  system clock, one CPU cycle per edge.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  ADDR_N  CPU-driven address of the current cycle.
- cpu_wdata  in  DATA_N  CPU-driven write data.
- cpu_we  in  1  CPU write strobe for the current cycle.
- rdy  out  1  CPU ready; 0 stalls the CPU.
- dma_oe  out  1  1 = DMA owns the bus; CPU address/data drivers must be released.
- dma_addr  out  ADDR_N  DMA bus address, valid when dma_oe=1.
- dma_we  out  1  DMA write strobe.
- dma_wdata  out  DATA_N  DMA write data.
- dma_rdata  in  DATA_N  bus read data.

Behaviour:
- Reset state: state=IDLE, rdy=1, dma_oe=0, dma_we=0, dma_addr=0, dma_wdata=0, page=0, index=0, parity=0.
- parity is a free-running toggle, inverting every clk. parity=0 is a GET (read) cycle; parity=1 is a PUT (write) cycle.
- Trigger: in IDLE, a cycle with cpu_we=1 and cpu_addr==TRIG_ADDR latches page<=cpu_wdata and moves to HALT. rdy goes 0 from the next cycle.
- HALT: rdy=0, dma_oe=0.
  - If cpu_we=1, stay in HALT. The 6502 only honours RDY on read cycles.
  - Otherwise this cycle is the CPU's dummy halted read. Next state is READ if the next cycle's parity is GET, else ALIGN.
- ALIGN: one idle cycle, rdy=0, dma_oe=0, then READ.
- READ (always a GET cycle): dma_oe=1, dma_we=0, dma_addr={page,index}. dma_rdata is latched into dma_wdata at the clock edge. Next state is WRITE.
- WRITE (always a PUT cycle): dma_oe=1, dma_we=1, dma_addr=OAM_ADDR, dma_wdata=latched byte.
  - If index==LEN-1: index wraps to 0 and the next state is IDLE. rdy=1 on the following cycle.
  - Otherwise index increments and the next state is READ.
- Stall length: rdy is low for 1+2*LEN cycles when no alignment is needed, 2+2*LEN with ALIGN. With LEN=256 that is 513/514 cycles, excluding extra HALT cycles.
- No address carry: index never carries into page; the source is always $XX00-$XXFF.
- Retrigger: writes to TRIG_ADDR while state!=IDLE are ignored. The CPU is halted then, but the bench still checks this.
- Reset mid-transfer: the next cycle is the reset state. rdy=1 and dma_oe=0 immediately; no partial continuation.
- dma_we is asserted only in WRITE. dma_oe is asserted only in READ/WRITE.
- All outputs are registered, with no combinational path from cpu_* to rdy.

Decomposition:
- dma_state_t enum {IDLE, HALT, ALIGN, READ, WRITE} goes in typepkg.
- TRIG_ADDR/OAM_ADDR defaults go in config.h, next to ADDR_N/DATA_N.
- The page latch reuses the existing register module (we = trigger, oe tied 0).
- No other sub-module; the FSM, parity toggle and index counter are a single always_ff block.

Test Plan:
- Trigger on GET cycle: CPU writes $02 to $4014 when the next cycle is PUT -> no ALIGN. Reads are $0200..$02FF, each followed by a write to $2004 with the same byte. rdy is low exactly 513 cycles.
- Trigger with opposite parity: same write one cycle later -> one ALIGN cycle, rdy low 514 cycles, first READ on a parity=0 cycle.
- Data integrity: preload page $07 with pattern i^$A5 -> the 256 writes to $2004 carry $A5,$A4,...,$5A in order. Index wraps to 0 with no access to $0800.
- HALT extension: hold cpu_we=1 for 2 extra cycles after the trigger -> state stays HALT for those cycles, then the transfer proceeds normally. Total rdy-low is 515/516.
- Reset mid-transfer: assert reset at byte 100 -> next cycle rdy=1, dma_oe=0, dma_we=0. A following $4014 write starts cleanly from index 0.
- Non-trigger writes: CPU writes to $4015 and a read from $4014 -> no transfer, rdy stays 1.

Source files
------------

// File: rtl/oam_dma_pkg.sv
// Shared types and default configuration for the sprite DMA engine.
package oam_dma_pkg;

  // System bus geometry and the two fixed register addresses.
  localparam int          ADDR_N_DEF    = 16;
  localparam int          DATA_N_DEF    = 8;
  localparam logic [15:0] TRIG_ADDR_DEF = 16'h4014;
  localparam logic [15:0] OAM_ADDR_DEF  = 16'h2004;
  localparam int          LEN_DEF       = 256;

  // Bus-cycle phase carried by the free-running parity toggle.
  localparam logic PAR_GET = 1'b0;
  localparam logic PAR_PUT = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

endpackage

// File: rtl/oam_dma_if.sv
// CPU-side and DMA-side bus signals seen by the sprite DMA engine.
interface oam_dma_if
  import oam_dma_pkg::*;
#(
  parameter int ADDR_N = ADDR_N_DEF,
  parameter int DATA_N = DATA_N_DEF
);

  logic [ADDR_N-1:0] cpu_addr;
  logic [DATA_N-1:0] cpu_wdata;
  logic              cpu_we;
  logic              rdy;
  logic              dma_oe;
  logic [ADDR_N-1:0] dma_addr;
  logic              dma_we;
  logic [DATA_N-1:0] dma_wdata;
  logic [DATA_N-1:0] dma_rdata;

  // The DMA engine itself.
  modport master (
    input  cpu_addr, cpu_wdata, cpu_we, dma_rdata,
    output rdy, dma_oe, dma_addr, dma_we, dma_wdata
  );

  // The rest of the system: CPU core and bus memory.
  modport slave (
    output cpu_addr, cpu_wdata, cpu_we, dma_rdata,
    input  rdy, dma_oe, dma_addr, dma_we, dma_wdata
  );

endinterface

// File: rtl/oam_dma_reg.sv
// Generic bus register: write-enabled storage with a gated read-back port.
module oam_dma_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic         oe,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rd_data
);

  // Capture d whenever the write enable is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

  assign rd_data = oe ? q : '0;

endmodule

// File: rtl/oam_dma.sv
// Sprite DMA engine: on a CPU write to the trigger register, stalls the CPU
// and copies one source page to the OAM data port as GET/PUT cycle pairs.
//
// state | meaning
// IDLE  | CPU owns the bus, watching for a trigger write
// HALT  | rdy low, waiting for the CPU's first halted (read) cycle
// ALIGN | one spare cycle so the first READ lands on a GET cycle
// READ  | DMA reads {page,index}; byte captured at the cycle end
// WRITE | DMA writes the captured byte to the OAM port
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter int               ADDR_N    = ADDR_N_DEF,
  parameter int               DATA_N    = DATA_N_DEF,
  parameter logic [ADDR_N-1:0] TRIG_ADDR = ADDR_N'(TRIG_ADDR_DEF),
  parameter logic [ADDR_N-1:0] OAM_ADDR  = ADDR_N'(OAM_ADDR_DEF),
  parameter int               LEN       = LEN_DEF
) (
  input  logic     clk,
  input  logic     reset,
  oam_dma_if.master bus
);

  if ((LEN < 1) || (LEN > (1 << DATA_N)) || ((LEN & (LEN - 1)) != 0)) begin : g_len_check
    $error("oam_dma: LEN must be a power of two no larger than 2**DATA_N");
  end

  localparam logic [DATA_N-1:0] IDX_LAST = DATA_N'(LEN - 1);

  dma_state_t        state, state_nxt;
  logic              parity;
  logic [DATA_N-1:0] index, index_nxt;
  logic [DATA_N-1:0] page;
  logic [DATA_N-1:0] page_rd_unused;
  logic              trig;

  logic              rdy_q, rdy_d;
  logic              oe_q, oe_d;
  logic              we_q, we_d;
  logic [ADDR_N-1:0] addr_q, addr_d;
  logic [DATA_N-1:0] wdata_q, wdata_d;

  // Retrigger writes are ignored because trig only fires from IDLE.
  assign trig = (state == IDLE) && bus.cpu_we && (bus.cpu_addr == TRIG_ADDR);

  // Source page latch; the read-back path is never used here.
  oam_dma_reg #(
    .W (DATA_N)
  ) u_page_reg (
    .clk     (clk),
    .reset   (reset),
    .we      (trig),
    .oe      (1'b0),
    .d       (bus.cpu_wdata),
    .q       (page),
    .rd_data (page_rd_unused)
  );

  // State register: FSM state, parity toggle, index counter and the
  // registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      parity  <= PAR_GET;
      index   <= '0;
      rdy_q   <= 1'b1;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      parity  <= ~parity;
      index   <= index_nxt;
      rdy_q   <= rdy_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state and index decode.
  always_comb begin
    state_nxt = state;
    index_nxt = index;
    case (state)
      IDLE: begin
        if (trig) state_nxt = HALT;
      end
      HALT: begin
        // A write cycle ignores RDY on the 6502, so wait for a read cycle.
        // The current parity is PUT exactly when the next cycle is GET.
        if (!bus.cpu_we) state_nxt = (parity == PAR_PUT) ? READ : ALIGN;
      end
      ALIGN: begin
        state_nxt = READ;
      end
      READ: begin
        state_nxt = WRITE;
      end
      WRITE: begin
        if (index == IDX_LAST) begin
          index_nxt = '0;
          state_nxt = IDLE;
        end else begin
          index_nxt = index + 1'b1;
          state_nxt = READ;
        end
      end
      default: begin
        state_nxt = IDLE;
        index_nxt = '0;
      end
    endcase
  end

  // Output decode for the coming cycle, registered by the state register.
  always_comb begin
    rdy_d   = (state_nxt == IDLE);
    oe_d    = (state_nxt == READ) || (state_nxt == WRITE);
    we_d    = (state_nxt == WRITE);
    addr_d  = '0;
    wdata_d = (state == READ) ? bus.dma_rdata : wdata_q;
    if (state_nxt == READ)  addr_d = ADDR_N'({page, index_nxt});
    if (state_nxt == WRITE) addr_d = OAM_ADDR;
  end

  assign bus.rdy       = rdy_q;
  assign bus.dma_oe    = oe_q;
  assign bus.dma_we    = we_q;
  assign bus.dma_addr  = addr_q;
  assign bus.dma_wdata = wdata_q;

endmodule
